// File: rtl/vtxbuf_ctrl_if.sv
// Bundle of the producer stream, consumer stream and vertex-buffer pins around vtxbuf_ctrl.
// The master modport is the controller; the slave modport is its surroundings.
interface vtxbuf_ctrl_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        buf_en;
    logic        buf_write;
    logic [3:0]  buf_addr;
    logic [31:0] buf_wdata;
    logic [31:0] buf_rdata;
    logic [4:0]  occupancy;

    modport master (
        input  in_valid, in_data, out_ready, buf_rdata,
        output in_ready, out_valid, out_data, out_last,
               buf_en, buf_write, buf_addr, buf_wdata, occupancy
    );

    modport slave (
        output in_valid, in_data, out_ready, buf_rdata,
        input  in_ready, out_valid, out_data, out_last,
               buf_en, buf_write, buf_addr, buf_wdata, occupancy
    );
endinterface

// File: rtl/vtxbuf_ctrl.sv
// Shares a single-port 16x32 vertex buffer between a word producer and a consumer
// that drains whole primitives; the buffer is run as a circular FIFO of vertex slots.
module vtxbuf_ctrl #(
    parameter int VTX_WORDS = 4,
    parameter int PRIM_VTX  = 3
) (
    input  logic          clk,
    input  logic          reset,
    vtxbuf_ctrl_if.master bus
);
    localparam int         SLOTS       = 16 / VTX_WORDS;
    localparam int         BURST_WORDS = PRIM_VTX * VTX_WORDS;
    localparam logic [3:0] WORD_MASK   = 4'(VTX_WORDS - 1);
    localparam logic [4:0] SLOTS_C     = 5'(SLOTS);
    localparam logic [4:0] PRIM_C      = 5'(PRIM_VTX);
    localparam logic [3:0] LAST_CNT    = 4'(BURST_WORDS - 1);
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_BURST    = 1'b1;

    logic [3:0]  wr_ptr_reg;
    logic [3:0]  rd_ptr_reg;
    logic [3:0]  cnt_reg;
    logic [4:0]  occ_reg;
    logic [0:0]  state_reg;
    logic        out_valid_reg;
    logic        out_last_reg;
    logic [31:0] out_data_reg;

    logic        partial;
    logic        space;
    logic        rd_go;
    logic        wr_go;
    logic        wr_first;
    logic        rd_last_word;
    logic        burst_end;
    logic [4:0]  complete;

    // A half-written vertex already owns its slot, so it never needs fresh space.
    always_comb begin
        partial      = (wr_ptr_reg & WORD_MASK) != 4'd0;
        complete     = occ_reg - {4'd0, partial};
        space        = partial || (occ_reg < SLOTS_C);
        rd_go        = !reset && (state_reg == ST_BURST) && (!out_valid_reg || bus.out_ready);
        wr_go        = !reset && !rd_go && bus.in_valid && space;
        wr_first     = (wr_ptr_reg & WORD_MASK) == 4'd0;
        rd_last_word = (rd_ptr_reg & WORD_MASK) == WORD_MASK;
        burst_end    = cnt_reg == LAST_CNT;
    end

    assign bus.in_ready  = !reset && !rd_go && space;
    assign bus.buf_en    = rd_go || wr_go;
    assign bus.buf_write = wr_go;
    assign bus.buf_addr  = rd_go ? rd_ptr_reg : (wr_go ? wr_ptr_reg : 4'd0);
    assign bus.buf_wdata = bus.in_data;
    assign bus.occupancy = occ_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= 4'd0;
            rd_ptr_reg    <= 4'd0;
            cnt_reg       <= 4'd0;
            occ_reg       <= 5'd0;
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= 32'd0;
        end else begin
            if (wr_go) begin
                wr_ptr_reg <= wr_ptr_reg + 4'd1;
                if (wr_first) begin
                    occ_reg <= occ_reg + 5'd1;
                end
            end

            // rd_go and wr_go are exclusive, so occ_reg has one writer per cycle.
            if (rd_go) begin
                rd_ptr_reg    <= rd_ptr_reg + 4'd1;
                out_data_reg  <= bus.buf_rdata;
                out_valid_reg <= 1'b1;
                out_last_reg  <= burst_end;
                if (rd_last_word) begin
                    occ_reg <= occ_reg - 5'd1;
                end
                if (burst_end) begin
                    cnt_reg   <= 4'd0;
                    state_reg <= ST_IDLE;
                end else begin
                    cnt_reg <= cnt_reg + 4'd1;
                end
            end else if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end

            if ((state_reg == ST_IDLE) && (complete >= PRIM_C)) begin
                state_reg <= ST_BURST;
            end
        end
    end
endmodule

// File: tb/tb_vtxbuf_ctrl.sv
// Randomized self-checking bench for vtxbuf_ctrl: the stream is compared against
// a FIFO-of-words view of the buffer, occupancy against ceil/floor slot arithmetic.
`timescale 1ns/1ps
module tb_vtxbuf_ctrl;
    localparam int VW = 4;
    localparam int PV = 3;
    localparam int PW = VW * PV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vtxbuf_ctrl_if bus();
    vtxbuf_ctrl #(.VTX_WORDS(VW), .PRIM_VTX(PV)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
        end else if (bus.buf_en && bus.buf_write) begin
            mem[bus.buf_addr] <= bus.buf_wdata;
        end
    end
    assign bus.buf_rdata = mem[bus.buf_addr];

    // Observation side: records what happened each cycle; judgement lives in the tests.
    logic [31:0] obs_data_q[$];
    logic        obs_last_q[$];
    logic [3:0]  rd_addr_q[$];
    logic [3:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int wr_n = 0, rd_n = 0, occ_model = 0;
    int occ_bad = 0, conflict_cnt = 0, overlap_cnt = 0, bad_wr_cnt = 0, stall_bad = 0;
    bit have_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            wr_n = 0;
            rd_n = 0;
            have_prev = 1'b0;
        end else begin
            occ_model = (wr_n + VW - 1) / VW - rd_n / VW;
            if (bus.occupancy !== 5'(occ_model)) occ_bad++;
            if (bus.buf_en && !bus.buf_write && bus.in_ready) conflict_cnt++;
            if (bus.buf_en && !bus.buf_write && bus.in_valid) overlap_cnt++;
            if ((bus.in_valid && bus.in_ready) !== (bus.buf_en && bus.buf_write)) bad_wr_cnt++;
            if (bus.buf_en && !bus.buf_write) begin
                rd_addr_q.push_back(bus.buf_addr);
                rd_n++;
            end
            if (bus.buf_en && bus.buf_write) begin
                wr_addr_q.push_back(bus.buf_addr);
                wr_data_q.push_back(bus.buf_wdata);
                wr_n++;
            end
            if (have_prev && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
                stall_bad++;
            have_prev = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_last = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                obs_data_q.push_back(bus.out_data);
                obs_last_q.push_back(bus.out_last);
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int base = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] d, output int waits, output bit ok);
        ok = 1'b0;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            waits++;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (obs_data_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        base = 0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data = 32'd0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data got=%0h want=0", bus.out_data); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%0b want=0", bus.out_last); end
        checks++; if (bus.occupancy !== 5'd0) begin errors++; $display("FAIL rst_occupancy got=%0d want=0", bus.occupancy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%0b want=0", bus.in_ready); end
        checks++; if (bus.buf_en !== 1'b0) begin errors++; $display("FAIL rst_buf_en got=%0b want=0", bus.buf_en); end
        tick();
        reset = 1'b0;
        base = 0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%0b want=1", bus.in_ready); end
        checks++; if (bus.buf_en !== 1'b0 || bus.buf_addr !== 4'd0) begin errors++; $display("FAIL idle_buf got en=%0b addr=%0d want en=0 addr=0", bus.buf_en, bus.buf_addr); end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_triangle();
        int n0, a0, w0, waits, tot_waits;
        bit ok;
        n0 = obs_data_q.size(); a0 = rd_addr_q.size(); w0 = wr_addr_q.size();
        tot_waits = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < PW; i++) begin
            put_word(32'h100 + 32'(i), waits, ok);
            tot_waits += waits;
            checks++; if (!ok) begin errors++; $display("FAIL single_put word=%0d got=timeout want=accepted", i); end
        end
        checks++; if (tot_waits != 0) begin errors++; $display("FAIL single_in_ready stall_cycles got=%0d want=0", tot_waits); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_lat_n1 out_valid got=%0b want=0", bus.out_valid); end
        tick();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.buf_en !== 1'b1 || bus.buf_write !== 1'b0) begin
            errors++; $display("FAIL single_lat_n2 got valid=%0b en=%0b wr=%0b want valid=0 en=1 wr=0", bus.out_valid, bus.buf_en, bus.buf_write); end
        tick();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h100) begin
            errors++; $display("FAIL single_first got valid=%0b data=%0h want valid=1 data=100", bus.out_valid, bus.out_data); end
        tick();
        wait_out(n0 + PW, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_drain got=%0d want=%0d words", obs_data_q.size() - n0, PW); end
        repeat (2) tick();
        if (ok) begin
            for (int i = 0; i < PW; i++) begin
                checks++; if (obs_data_q[n0+i] !== 32'h100 + 32'(i) || obs_last_q[n0+i] !== (i == PW - 1)) begin
                    errors++; $display("FAIL single_word %0d got=%0h/%0b want=%0h/%0b", i, obs_data_q[n0+i], obs_last_q[n0+i], 32'h100 + 32'(i), i == PW - 1); end
                checks++; if (rd_addr_q[a0+i] !== 4'((base + i) % 16) || wr_addr_q[w0+i] !== 4'((base + i) % 16)) begin
                    errors++; $display("FAIL single_addr %0d got rd=%0d wr=%0d want=%0d", i, rd_addr_q[a0+i], wr_addr_q[w0+i], (base + i) % 16); end
                checks++; if (wr_data_q[w0+i] !== 32'h100 + 32'(i)) begin
                    errors++; $display("FAIL single_wdata %0d got=%0h want=%0h", i, wr_data_q[w0+i], 32'h100 + 32'(i)); end
            end
        end
        checks++; if (bus.occupancy !== 5'd0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL single_end got occ=%0d valid=%0b want occ=0 valid=0", bus.occupancy, bus.out_valid); end
        base += PW;
        $display("test_single_triangle done");
    endtask

    task automatic test_full_buffer();
        int n0, waits, late_waits;
        bit ok;
        pulse_reset();
        n0 = obs_data_q.size();
        late_waits = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            put_word(32'h200 + 32'(i), waits, ok);
            if (i >= PW) late_waits += waits;
            checks++; if (!ok) begin errors++; $display("FAIL full_put word=%0d got=timeout want=accepted", i); end
        end
        checks++; if (late_waits != 1) begin errors++; $display("FAIL full_grant_stall got=%0d want=1", late_waits); end
        bus.in_valid = 1'b1;
        bus.in_data = 32'h210;
        @(negedge clk);
        checks++; if (bus.occupancy !== 5'd4) begin errors++; $display("FAIL full_occupancy got=%0d want=4", bus.occupancy); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h200 || bus.out_last !== 1'b0) begin
            errors++; $display("FAIL full_stalled_head got valid=%0b data=%0h last=%0b want 1/200/0", bus.out_valid, bus.out_data, bus.out_last); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready cycle=%0d got=1 want=0", c); end
            tick();
            @(negedge clk);
        end
        tick();
        bus.out_ready = 1'b1;
        for (int i = 16; i < 2 * PW; i++) begin
            put_word(32'h200 + 32'(i), waits, ok);
            checks++; if (!ok) begin errors++; $display("FAIL full_refill word=%0d got=timeout want=accepted", i); end
        end
        wait_out(n0 + 2 * PW, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_drain got=%0d want=%0d words", obs_data_q.size() - n0, 2 * PW); end
        repeat (2) tick();
        if (ok) begin
            for (int i = 0; i < 2 * PW; i++) begin
                checks++; if (obs_data_q[n0+i] !== 32'h200 + 32'(i) || obs_last_q[n0+i] !== ((i % PW) == PW - 1)) begin
                    errors++; $display("FAIL full_word %0d got=%0h/%0b want=%0h/%0b", i, obs_data_q[n0+i], obs_last_q[n0+i], 32'h200 + 32'(i), (i % PW) == PW - 1); end
            end
        end
        checks++; if (bus.occupancy !== 5'd0) begin errors++; $display("FAIL full_end_occ got=%0d want=0", bus.occupancy); end
        base = 2 * PW;
        $display("test_full_buffer done");
    endtask

    task automatic test_wrap_random();
        int n0, a0, s0, o0, b0, c0, put_fail;
        bit ok, prod_done;
        n0 = obs_data_q.size(); a0 = rd_addr_q.size();
        s0 = stall_bad; o0 = occ_bad; b0 = bad_wr_cnt; c0 = conflict_cnt;
        put_fail = 0;
        prod_done = 1'b0;
        fork
            begin
                int waits;
                bit pok;
                for (int i = 0; i < 5 * PW; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    put_word(32'h400 + 32'(i), waits, pok);
                    if (!pok) put_fail++;
                end
                prod_done = 1'b1;
            end
            begin
                int guard = 0;
                while ((!prod_done || obs_data_q.size() < n0 + 5 * PW) && guard < 4000) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    tick();
                    guard++;
                end
            end
        join
        bus.out_ready = 1'b1;
        checks++; if (put_fail != 0) begin errors++; $display("FAIL wrap_put timeouts got=%0d want=0", put_fail); end
        wait_out(n0 + 5 * PW, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_drain got=%0d want=%0d words", obs_data_q.size() - n0, 5 * PW); end
        repeat (3) tick();
        checks++; if (obs_data_q.size() != n0 + 5 * PW) begin errors++; $display("FAIL wrap_count got=%0d want=%0d", obs_data_q.size() - n0, 5 * PW); end
        if (ok) begin
            for (int i = 0; i < 5 * PW; i++) begin
                checks++; if (obs_data_q[n0+i] !== 32'h400 + 32'(i) || obs_last_q[n0+i] !== ((i % PW) == PW - 1)) begin
                    errors++; $display("FAIL wrap_word %0d got=%0h/%0b want=%0h/%0b", i, obs_data_q[n0+i], obs_last_q[n0+i], 32'h400 + 32'(i), (i % PW) == PW - 1); end
                checks++; if (rd_addr_q[a0+i] !== 4'((base + i) % 16)) begin
                    errors++; $display("FAIL wrap_rd_addr %0d got=%0d want=%0d", i, rd_addr_q[a0+i], (base + i) % 16); end
            end
        end
        checks++; if (stall_bad != s0) begin errors++; $display("FAIL wrap_stall_hold bad_cycles got=%0d want=0", stall_bad - s0); end
        checks++; if (occ_bad != o0) begin errors++; $display("FAIL wrap_occupancy_track bad_cycles got=%0d want=0", occ_bad - o0); end
        checks++; if (bad_wr_cnt != b0 || conflict_cnt != c0) begin
            errors++; $display("FAIL wrap_grant got bad_wr=%0d conflicts=%0d want 0/0", bad_wr_cnt - b0, conflict_cnt - c0); end
        checks++; if (bus.occupancy !== 5'd0) begin errors++; $display("FAIL wrap_end_occ got=%0d want=0", bus.occupancy); end
        base += 5 * PW;
        $display("test_wrap_random done");
    endtask

    task automatic test_simultaneous();
        int n0, c0, b0, v0, waits;
        bit ok;
        n0 = obs_data_q.size();
        c0 = conflict_cnt; b0 = bad_wr_cnt; v0 = overlap_cnt;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2 * PW; i++) begin
            put_word(32'h500 + 32'(i), waits, ok);
            checks++; if (!ok) begin errors++; $display("FAIL simul_put word=%0d got=timeout want=accepted", i); end
        end
        wait_out(n0 + 2 * PW, ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_drain got=%0d want=%0d words", obs_data_q.size() - n0, 2 * PW); end
        checks++; if (overlap_cnt == v0) begin errors++; $display("FAIL simul_overlap read_grants_with_in_valid got=0 want>0"); end
        checks++; if (conflict_cnt != c0) begin errors++; $display("FAIL simul_in_ready_on_read got=%0d want=0", conflict_cnt - c0); end
        checks++; if (bad_wr_cnt != b0) begin errors++; $display("FAIL simul_write_slot got=%0d want=0", bad_wr_cnt - b0); end
        if (ok) begin
            for (int i = 0; i < 2 * PW; i++) begin
                checks++; if (obs_data_q[n0+i] !== 32'h500 + 32'(i)) begin
                    errors++; $display("FAIL simul_word %0d got=%0h want=%0h", i, obs_data_q[n0+i], 32'h500 + 32'(i)); end
            end
        end
        base += 2 * PW;
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid_burst();
        int n0, a0, waits;
        bit ok;
        bus.out_ready = 1'b1;
        n0 = obs_data_q.size();
        for (int i = 0; i < PW; i++) begin
            put_word(32'h600 + 32'(i), waits, ok);
            checks++; if (!ok) begin errors++; $display("FAIL mid_put word=%0d got=timeout want=accepted", i); end
        end
        wait_out(n0 + 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_partial got=%0d want=5 words", obs_data_q.size() - n0); end
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 5'd0) begin
            errors++; $display("FAIL mid_reset got valid=%0b occ=%0d want 0/0", bus.out_valid, bus.occupancy); end
        tick();
        reset = 1'b0;
        base = 0;
        n0 = obs_data_q.size();
        a0 = rd_addr_q.size();
        repeat (15) tick();
        checks++; if (obs_data_q.size() != n0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_no_ghost got words=%0d valid=%0b want 0/0", obs_data_q.size() - n0, bus.out_valid); end
        for (int i = 0; i < PW; i++) begin
            put_word(32'h700 + 32'(i), waits, ok);
            checks++; if (!ok) begin errors++; $display("FAIL mid_fresh_put word=%0d got=timeout want=accepted", i); end
        end
        wait_out(n0 + PW, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_fresh_drain got=%0d want=%0d words", obs_data_q.size() - n0, PW); end
        if (ok) begin
            for (int i = 0; i < PW; i++) begin
                checks++; if (obs_data_q[n0+i] !== 32'h700 + 32'(i) || obs_last_q[n0+i] !== (i == PW - 1) || rd_addr_q[a0+i] !== 4'(i)) begin
                    errors++; $display("FAIL mid_fresh_word %0d got=%0h/%0b@%0d want=%0h/%0b@%0d", i, obs_data_q[n0+i], obs_last_q[n0+i], rd_addr_q[a0+i], 32'h700 + 32'(i), i == PW - 1, i); end
            end
        end
        repeat (2) tick();
        checks++; if (bus.occupancy !== 5'd0) begin errors++; $display("FAIL mid_end_occ got=%0d want=0", bus.occupancy); end
        $display("test_reset_mid_burst done");
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = 32'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_triangle();
        test_full_buffer();
        test_wrap_random();
        test_simultaneous();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vtxbuf_ctrl.md
# vtxbuf_ctrl

Controller that sequences and shares the single-port 16 x 32-bit vertex buffer between a vertex loader (producer, writes vertex words) and primitive setup (consumer, reads whole primitives). It manages the buffer as a circular FIFO of fixed-size vertex slots. It grants exactly one access per cycle and streams each primitive of PRIM_VTX vertices out through a registered valid/ready port. The block sits between the vertex fetch stage and triangle setup, and drives the buffer's en/write/Addr/wData pins directly.

## Interface
- VTX_WORDS, 4, 32-bit words per vertex; legal values 1, 2, 4; SLOTS = 16 / VTX_WORDS
- PRIM_VTX, 3, vertices per primitive; 1 <= PRIM_VTX <= SLOTS
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  producer word valid
- in_data  in  32  producer word
- in_ready  out  1  word accepted this cycle when in_valid && in_ready
- out_valid  out  1  output register holds a word
- out_data  out  32  primitive word (vertex-major, word 0 first)
- out_last  out  1  final word of the primitive
- out_ready  in  1  consumer accepts when out_valid && out_ready
- buf_en  out  1  buffer enable
- buf_write  out  1  1 = write, 0 = read
- buf_addr  out  4  buffer word address
- buf_wdata  out  32  buffer write data (= in_data)
- buf_rdata  in  32  buffer read data; combinational from buf_addr
- occupancy  out  5  slots reserved (partial or complete, not yet fully read)

## Operation
- State: wr_ptr[3:0] and rd_ptr[3:0] (word addresses, wrap 15 -> 0), occ (0..SLOTS), FSM {IDLE, BURST}, burst word counter (0..PRIM_VTX*VTX_WORDS-1).
- partial = (wr_ptr mod VTX_WORDS != 0); complete = occ - partial.
- Space rule: a word may be written if partial, or if occ < SLOTS.
- Port grant, evaluated each cycle:
  - rd_go = (state == BURST) && (!out_valid || out_ready).
  - wr_go = !rd_go && in_valid && space.
  - Read has priority. At most one of rd_go/wr_go is set.
- in_ready = !rd_go && space; it combinationally depends on out_ready.
- wr_go: buf_en=1, buf_write=1, buf_addr=wr_ptr; wr_ptr+1. If the word is the first word of a vertex, occ+1.
- rd_go: buf_en=1, buf_write=0, buf_addr=rd_ptr; out_data<=buf_rdata, out_valid<=1, out_last<=(counter==last); rd_ptr+1, counter+1.
  - If the word is the last word of a vertex, occ-1 (the slot is freed immediately).
  - On the last word of the primitive: counter<=0, state<=IDLE.
- No grant: buf_en=0, buf_write=0, buf_addr=0.
- Output handshake: if out_valid && out_ready && !rd_go, then out_valid<=0. While stalled, out_data and out_last hold steady.
- IDLE -> BURST when complete >= PRIM_VTX; no read occurs in the transition cycle, and writes are still allowed.
- BURST always runs to completion. All vertices it needs are complete at entry, so freed slots may be refilled mid-burst.
- occ never increments and decrements in the same cycle (single port).
- Reset: wr_ptr=rd_ptr=0, occ=0, state IDLE, counter 0, out_valid=0, out_data=0, out_last=0, in_ready=0, buf_en=0. The buffer's own reset clears contents in parallel.
- Reset mid-burst or mid-vertex discards everything; no partial primitive is emitted afterward.

## Timing
- Write: accepted word is in the buffer at the next edge; in_ready can be 1 every cycle outside read grants.
- Primitive latency: last word of the PRIM_VTX-th vertex written at edge N -> BURST at N+1 -> first read grant in cycle N+1..N+2 -> out_valid at N+2.
- Throughput: 1 word/cycle with out_ready held high. 12 words for the defaults, with out_last on the 12th.
- Back-pressure: out_ready low with out_valid high blocks reads. The producer may use the port in those cycles.
- Full: occ == SLOTS and !partial -> in_ready=0 until a vertex's last word is read. It rises in the cycle after that read edge, if the port is free.

## Test plan
- Reset then idle: check all outputs after reset, including out_data=0 and occupancy=0. in_ready=1 after reset deasserts, with in_valid low.
- Single triangle: write 12 words 0x100..0x10B, out_ready=1.
  - Required: out_data 0x100..0x10B in order, out_last only on 0x10B, occupancy back to 0.
  - buf_addr on reads is 0..11.
- Full buffer: write 16 words with out_ready=0 and PRIM_VTX=3.
  - After word 12 the burst starts and reads word 0 into out_data, then stalls.
  - Words 13-16 are accepted (occupancy=4). Word 17 sees in_ready=0 until vertex 0 is read.
- Wrap-around: stream 5 triangles (60 words) with random out_ready.
  - Required: wr_ptr/rd_ptr wrap 15->0, and output order equals input order.
  - Every 12th word has out_last=1; no word is lost or duplicated.
- Simultaneous demand: in_valid and out_ready both high during a burst.
  - Required: in_ready=0 in every read-grant cycle, and writes land only in non-read cycles.
- Reset mid-burst: assert reset after 5 of 12 words are output.
  - Required: out_valid=0 on the next edge, occupancy=0.
  - A fresh 12-word triangle afterward streams correctly from address 0.
